// File: rtl/thread_fetch_unit_pkg.sv
// Core-wide thread and fetch-address sizing, shared with the fetch/decode register
// and the branch unit.
package thread_fetch_unit_pkg;

    localparam int THREAD_BITS     = 2;
    localparam int NUM_THREADS     = 2 ** THREAD_BITS;
    localparam int INST_ADDR_WIDTH = 9;
    localparam int RESET_PC        = 0;

endpackage

// File: rtl/thread_fetch_unit_rr_thread_select.sv
// Combinational round-robin picker: first requester after the last grant, wrapping,
// with the last grantee itself considered last.
module rr_thread_select #(
    parameter int THREAD_BITS = 2,
    parameter int NUM_THREADS = 2 ** THREAD_BITS
) (
    input  logic [NUM_THREADS-1:0] req,
    input  logic [THREAD_BITS-1:0] last_grant,
    output logic [THREAD_BITS-1:0] grant,
    output logic                   any_valid
);

    logic [THREAD_BITS-1:0] w_idx;
    logic                   w_found;

    always_comb begin
        grant   = last_grant;
        w_found = 1'b0;
        w_idx   = '0;
        // Offset NUM_THREADS truncates to zero, so last_grant is scanned last.
        for (int k = 1; k <= NUM_THREADS; k++) begin
            w_idx = last_grant + THREAD_BITS'(k);
            if (!w_found && req[w_idx]) begin
                grant   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/thread_fetch_unit.sv
// Fetch-stage thread scheduler and per-thread PC bank with branch redirect and
// same-cycle bypass into the issued address.
module thread_fetch_unit
    import thread_fetch_unit_pkg::*;
#(
    parameter int THREAD_BITS_P     = THREAD_BITS,
    parameter int INST_ADDR_WIDTH_P = INST_ADDR_WIDTH,
    parameter int RESET_PC_P        = RESET_PC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2**THREAD_BITS_P-1:0]  thread_active,
    input  logic                         branch_valid,
    input  logic [THREAD_BITS_P-1:0]     branch_thread,
    input  logic [INST_ADDR_WIDTH_P-1:0] branch_target,
    output logic [INST_ADDR_WIDTH_P-1:0] inst_addr,
    output logic [THREAD_BITS_P-1:0]     thread_id_out,
    output logic                         fetch_valid
);

    localparam int NT = 2 ** THREAD_BITS_P;

    logic [INST_ADDR_WIDTH_P-1:0] r_pc [NT];
    logic [THREAD_BITS_P-1:0]     r_last_tid;
    logic [INST_ADDR_WIDTH_P-1:0] r_inst_addr;
    logic [THREAD_BITS_P-1:0]     r_thread_id;
    logic                         r_fetch_valid;

    logic [THREAD_BITS_P-1:0]     w_sel;
    logic                         w_any_active;
    logic [INST_ADDR_WIDTH_P-1:0] w_issue_addr;

    rr_thread_select #(
        .THREAD_BITS (THREAD_BITS_P),
        .NUM_THREADS (NT)
    ) u_rr_thread_select (
        .req        (thread_active),
        .last_grant (r_last_tid),
        .grant      (w_sel),
        .any_valid  (w_any_active)
    );

    assign w_issue_addr = (branch_valid && (branch_thread == w_sel)) ? branch_target
                                                                      : r_pc[w_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NT; i++) begin
                r_pc[i] <= INST_ADDR_WIDTH_P'(RESET_PC_P);
            end
            r_last_tid    <= THREAD_BITS_P'(NT - 1);
            r_inst_addr   <= INST_ADDR_WIDTH_P'(RESET_PC_P);
            r_thread_id   <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            if (branch_valid) begin
                r_pc[branch_thread] <= branch_target;
            end
            // The increment is written after the redirect so a bypassed branch
            // to the selected thread resolves to target+1.
            if (en) begin
                if (w_any_active) begin
                    r_pc[w_sel]   <= w_issue_addr + 1'b1;
                    r_inst_addr   <= w_issue_addr;
                    r_thread_id   <= w_sel;
                    r_last_tid    <= w_sel;
                    r_fetch_valid <= 1'b1;
                end else begin
                    r_fetch_valid <= 1'b0;
                end
            end
        end
    end

    assign inst_addr     = r_inst_addr;
    assign thread_id_out = r_thread_id;
    assign fetch_valid   = r_fetch_valid;

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Directed bench for thread_fetch_unit: round-robin order, masking, redirects,
// bypass, PC wrap, stall and mid-stream reset.
module tb_thread_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] thread_active;
    logic       branch_valid;
    logic [1:0] branch_thread;
    logic [8:0] branch_target;
    logic [8:0] inst_addr;
    logic [1:0] thread_id_out;
    logic       fetch_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    thread_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .thread_active (thread_active),
        .branch_valid  (branch_valid),
        .branch_thread (branch_thread),
        .branch_target (branch_target),
        .inst_addr     (inst_addr),
        .thread_id_out (thread_id_out),
        .fetch_valid   (fetch_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [1:0] et,
                       input logic [8:0] ea);
        checks++;
        assert (fetch_valid === ev && thread_id_out === et && inst_addr === ea)
        else begin
            errors++;
            $error("FAIL %s: observed fv=%0b tid=%0d addr=%03h expected fv=%0b tid=%0d addr=%03h",
                   tag, fetch_valid, thread_id_out, inst_addr, ev, et, ea);
        end
    endtask

    task automatic go(input string tag, input logic [1:0] et, input logic [8:0] ea);
        step();
        chk(tag, 1'b1, et, ea);
    endtask

    task automatic branch(input logic v, input logic [1:0] t, input logic [8:0] a);
        branch_valid  = v;
        branch_thread = t;
        branch_target = a;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; thread_active = 4'h0;
        branch(1'b0, 2'd0, 9'h000);
        step(); step();
        chk("reset", 1'b0, 2'd0, 9'h000);

        // All threads active: 0,1,2,3 each advancing once per round.
        reset = 1'b0; en = 1'b1; thread_active = 4'hF;
        go("rr0", 2'd0, 9'h000); go("rr1", 2'd1, 9'h000);
        go("rr2", 2'd2, 9'h000); go("rr3", 2'd3, 9'h000);
        go("rr4", 2'd0, 9'h001); go("rr5", 2'd1, 9'h001);
        go("rr6", 2'd2, 9'h001); go("rr7", 2'd3, 9'h001);

        // Mask 0101: threads 0 and 2 alternate.
        thread_active = 4'b0101;
        go("mask0", 2'd0, 9'h002); go("mask1", 2'd2, 9'h002);
        go("mask2", 2'd0, 9'h003); go("mask3", 2'd2, 9'h003);

        // No thread active: invalid, outputs hold; redirect still lands.
        thread_active = 4'h0;
        step(); chk("idle0", 1'b0, 2'd2, 9'h003);
        branch(1'b1, 2'd3, 9'h0C0);
        step(); chk("idle1", 1'b0, 2'd2, 9'h003);
        branch(1'b0, 2'd0, 9'h000);

        // Non-bypass redirect of thread 1 while thread 3 is selected.
        thread_active = 4'hF;
        branch(1'b1, 2'd1, 9'h1F0);
        go("nb_t3", 2'd3, 9'h0C0);
        branch(1'b0, 2'd0, 9'h000);
        go("nb_t0", 2'd0, 9'h004);
        go("nb_t1a", 2'd1, 9'h1F0);
        go("nb_t2", 2'd2, 9'h004);
        go("nb_t3b", 2'd3, 9'h0C1);
        go("nb_t0b", 2'd0, 9'h005);
        go("nb_t1b", 2'd1, 9'h1F1);

        // Bypass: redirect thread 2 in the cycle it is selected.
        branch(1'b1, 2'd2, 9'h0AA);
        go("byp", 2'd2, 9'h0AA);
        branch(1'b0, 2'd0, 9'h000);
        go("byp_t3", 2'd3, 9'h0C2);

        // Wrap: thread 0 issues 1FF, next turn 000.
        branch(1'b1, 2'd0, 9'h1FF);
        go("wrap_a", 2'd0, 9'h1FF);
        branch(1'b0, 2'd0, 9'h000);
        go("wrap_t1", 2'd1, 9'h1F2);
        go("wrap_t2", 2'd2, 9'h0AB);
        go("wrap_t3", 2'd3, 9'h0C3);
        go("wrap_b", 2'd0, 9'h000);

        // Stall with a pending redirect of thread 3.
        en = 1'b0;
        branch(1'b1, 2'd3, 9'h010);
        go("stall0", 2'd0, 9'h000);
        go("stall1", 2'd0, 9'h000);
        go("stall2", 2'd0, 9'h000);
        branch(1'b0, 2'd0, 9'h000);
        en = 1'b1;
        go("res_t1", 2'd1, 9'h1F3);
        go("res_t2", 2'd2, 9'h0AC);
        go("res_t3", 2'd3, 9'h010);
        go("res_t0", 2'd0, 9'h001);

        // Mid-stream reset discards the same-cycle branch.
        reset = 1'b1;
        branch(1'b1, 2'd2, 9'h055);
        step(); chk("rst_mid", 1'b0, 2'd0, 9'h000);
        reset = 1'b0;
        branch(1'b0, 2'd0, 9'h000);
        go("post0", 2'd0, 9'h000); go("post1", 2'd1, 9'h000);
        go("post2", 2'd2, 9'h000); go("post3", 2'd3, 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
